// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester read arbiter for the image RAM read port B
//
// Purpose: lets the VGA pixel fetch path (V) and the image-processing engine (P)
// share one RAM read port. Each cycle at most one read is issued. A tag pipeline
// with the same latency as the RAM sends each returned word to the requester that
// issued it. V has fixed priority.
//
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to add a starvation guard.
// After STARVE_MAX consecutive blocked cycles, P wins the next contested cycle.
// The STARVE_MAX parameter exists only in that build.
//
// Ports:
//   clk_FPGA, rst_n              clock, asynchronous active-low reset
//   vga_req/vga_addr/vga_gnt     V request, address, combinational grant
//   vga_rvalid/vga_rdata         V read response
//   proc_req/proc_addr/proc_gnt  P request, address, combinational grant
//   proc_rvalid/proc_rdata       P read response
//   mem_addr/mem_rd/mem_q        RAM port B address, read strobe, read data
//   inflight                     issued reads whose data has not yet been delivered
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
`ifdef VRAM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = 8
`endif
) (
    input  logic              clk_FPGA,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic              proc_gnt,
    output logic              proc_rvalid,
    output logic [DATA_W-1:0] proc_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_q,
    output logic [2:0]        inflight
);

    // Stage i holds the read issued i+1 edges ago. The last stage lines up with
    // the edge at which mem_q carries that read's data.
    logic [RD_LAT:0] tag_v;
    logic [RD_LAT:0] tag_id;    // 0 = V, 1 = P
    logic            force_p;
    logic            xfer;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;
    logic       force_q;

    // The flag is set on the same edge at which the count reaches STARVE_MAX,
    // so P wins the very next cycle.
    always_ff @(posedge clk_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
            force_q    <= 1'b0;
        end else if (!proc_req || proc_gnt) begin
            starve_cnt <= 8'd0;
            force_q    <= 1'b0;
        end else begin
            if (starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;
            if (starve_cnt == 8'(STARVE_MAX - 1))
                force_q <= 1'b1;
        end
    end

    assign force_p = force_q;
`else
    assign force_p = 1'b0;
`endif

    // Grants depend only on the request inputs, reset and registered state.
    // They never depend on the addresses.
    assign vga_gnt  = rst_n & vga_req & (~proc_req | ~force_p);
    assign proc_gnt = rst_n & proc_req & (~vga_req | force_p);
    assign xfer     = vga_gnt | proc_gnt;

    always_ff @(posedge clk_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            mem_rd <= xfer;
            if (xfer)
                mem_addr <= proc_gnt ? proc_addr : vga_addr;
        end
    end

    always_ff @(posedge clk_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[RD_LAT-1:0], xfer};
            tag_id <= {tag_id[RD_LAT-1:0], proc_gnt};
        end
    end

    always_ff @(posedge clk_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            vga_rvalid  <= 1'b0;
            proc_rvalid <= 1'b0;
            vga_rdata   <= '0;
            proc_rdata  <= '0;
        end else begin
            vga_rvalid  <= tag_v[RD_LAT] & ~tag_id[RD_LAT];
            proc_rvalid <= tag_v[RD_LAT] &  tag_id[RD_LAT];
            if (tag_v[RD_LAT] && !tag_id[RD_LAT])
                vga_rdata <= mem_q;
            if (tag_v[RD_LAT] && tag_id[RD_LAT])
                proc_rdata <= mem_q;
        end
    end

    // At most RD_LAT+2 reads can be outstanding, so the 3-bit sum never wraps
    // for RD_LAT up to 4.
    always_comb begin
        inflight = 3'(vga_rvalid) + 3'(proc_rvalid);
        for (int i = 0; i <= RD_LAT; i++)
            inflight = inflight + 3'(tag_v[i]);
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk_FPGA = 1'b0;
    logic        rst_n;
    logic        vga_req, proc_req;
    logic [15:0] vga_addr, proc_addr;
    logic        vga_gnt, proc_gnt;
    logic        vga_rvalid, proc_rvalid;
    logic [63:0] vga_rdata, proc_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [63:0] mem_q = 64'd0;
    logic [2:0]  inflight;

    int checks   = 0;
    int failures = 0;

    vram_arbiter dut (
        .clk_FPGA   (clk_FPGA),
        .rst_n      (rst_n),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .proc_req   (proc_req),
        .proc_addr  (proc_addr),
        .proc_gnt   (proc_gnt),
        .proc_rvalid(proc_rvalid),
        .proc_rdata (proc_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_q      (mem_q),
        .inflight   (inflight)
    );

    always #5 clk_FPGA = ~clk_FPGA;

    function automatic logic [63:0] model(input logic [15:0] a);
        return {16'hA5A5, 32'h0, a};
    endfunction

    // RAM with a read latency of one cycle
    always @(posedge clk_FPGA)
        if (mem_rd) mem_q <= model(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_FPGA);
        #1;
    endtask

    int          vcnt, pcnt, both, nresp, both_rv, peak, rvcnt;
    logic [31:0] pmask;
    logic [63:0] rdat [0:15];
    logic        rport [0:15];

    initial begin
        // Reset state, with grants blocked while reset is asserted
        rst_n = 1'b0; vga_req = 1'b1; proc_req = 1'b1; vga_addr = 16'h0; proc_addr = 16'h0;
        #3;
        chk("rst_vga_gnt", 64'(vga_gnt), 64'd0);
        chk("rst_proc_gnt", 64'(proc_gnt), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_rvalids", 64'({vga_rvalid, proc_rvalid}), 64'd0);
        chk("rst_rdata", vga_rdata | proc_rdata, 64'd0);
        vga_req = 1'b0; proc_req = 1'b0;
        tick; tick;
        rst_n = 1'b1;

        // Single V read at address 0x0010
        vga_req = 1'b1; vga_addr = 16'h0010;
        #1;
        chk("t1_vga_gnt", 64'(vga_gnt), 64'd1);
        chk("t1_proc_gnt", 64'(proc_gnt), 64'd0);
        tick;
        vga_req = 1'b0;
        chk("t1_mem_rd", 64'(mem_rd), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h0010);
        chk("t1_rvalid_early", 64'(vga_rvalid), 64'd0);
        chk("t1_inflight1", 64'(inflight), 64'd1);
        tick;
        chk("t1_mem_rd_low", 64'(mem_rd), 64'd0);
        chk("t1_rvalid_early2", 64'(vga_rvalid), 64'd0);
        tick;
        chk("t1_vga_rvalid", 64'(vga_rvalid), 64'd1);
        chk("t1_vga_rdata", vga_rdata, 64'hA5A5_0000_0000_0010);
        chk("t1_proc_rvalid", 64'(proc_rvalid), 64'd0);
        chk("t1_inflight_rv", 64'(inflight), 64'd1);
        tick;
        chk("t1_rvalid_pulse", 64'(vga_rvalid), 64'd0);
        chk("t1_rdata_hold", vga_rdata, 64'hA5A5_0000_0000_0010);
        chk("t1_inflight0", 64'(inflight), 64'd0);

        // Both requesters active for 20 consecutive cycles
        vcnt = 0; pcnt = 0; both = 0; pmask = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            vga_req = 1'b1; proc_req = 1'b1;
            vga_addr = 16'h0100 + 16'(i); proc_addr = 16'h0200 + 16'(i);
            #1;
            if (vga_gnt) vcnt++;
            if (proc_gnt) begin pcnt++; pmask[i] = 1'b1; end
            if (vga_gnt && proc_gnt) both++;
            tick;
        end
        vga_req = 1'b0; proc_req = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("t2_vga_grants", 64'(vcnt), 64'd18);
        chk("t2_proc_grants", 64'(pcnt), 64'd2);
        chk("t2_proc_cycles", 64'(pmask), 64'h0004_0200);
`else
        chk("t2_vga_grants", 64'(vcnt), 64'd20);
        chk("t2_proc_grants", 64'(pcnt), 64'd0);
        chk("t2_proc_cycles", 64'(pmask), 64'd0);
`endif
        chk("t2_both_gnt", 64'(both), 64'd0);
        for (int i = 0; i < 5; i++) tick;
        chk("t2_drained", 64'(inflight), 64'd0);

        // Alternating V/P back-to-back transfers, addresses 1..6
        nresp = 0; both_rv = 0; peak = 0;
        for (int k = 1; k <= 12; k++) begin
            vga_req  = (k <= 6) && (k % 2 == 1);
            proc_req = (k <= 6) && (k % 2 == 0);
            vga_addr = 16'(k); proc_addr = 16'(k);
            tick;
            if (vga_rvalid && proc_rvalid) both_rv++;
            if (vga_rvalid && nresp < 16) begin rport[nresp] = 1'b0; rdat[nresp] = vga_rdata; nresp++; end
            if (proc_rvalid && nresp < 16) begin rport[nresp] = 1'b1; rdat[nresp] = proc_rdata; nresp++; end
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        vga_req = 1'b0; proc_req = 1'b0;
        chk("t3_nresp", 64'(nresp), 64'd6);
        chk("t3_both_rvalid", 64'(both_rv), 64'd0);
        chk("t3_inflight_peak", 64'(peak), 64'd3);
        chk("t3_drained", 64'(inflight), 64'd0);
        for (int i = 0; i < 6 && i < nresp; i++) begin
            chk($sformatf("t3_port%0d", i), 64'(rport[i]), 64'(i % 2));
            chk($sformatf("t3_data%0d", i), rdat[i], model(16'(i + 1)));
        end

        // Reset while two reads are in flight
        vga_req = 1'b1; vga_addr = 16'h0030;
        tick;
        vga_req = 1'b0; proc_req = 1'b1; proc_addr = 16'h0031;
        tick;
        proc_req = 1'b0;
        chk("t4_inflight2", 64'(inflight), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t4_mem_rd", 64'(mem_rd), 64'd0);
        chk("t4_mem_addr", 64'(mem_addr), 64'd0);
        chk("t4_inflight", 64'(inflight), 64'd0);
        chk("t4_vga_rdata", vga_rdata, 64'd0);
        chk("t4_proc_rdata", proc_rdata, 64'd0);
        tick;
        rst_n = 1'b1;
        rvcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (vga_rvalid || proc_rvalid) rvcnt++;
        end
        chk("t4_no_stale_rvalid", 64'(rvcnt), 64'd0);
        vga_req = 1'b1; vga_addr = 16'h0040;
        #1;
        chk("t4_new_gnt", 64'(vga_gnt), 64'd1);
        tick;
        vga_req = 1'b0;
        tick; tick;
        chk("t4_new_rvalid", 64'(vga_rvalid), 64'd1);
        chk("t4_new_rdata", vga_rdata, model(16'h0040));
        chk("t4_new_proc_rvalid", 64'(proc_rvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares the single 64-bit read port (port B) of the image RAM between two requesters:
  - the VGA pixel fetch path (requester V);
  - the image-processing engine (requester P).
- Sequences at most one read per clock, issues address and read strobe to the RAM, and routes returned data to the issuing requester through a latency-matched tag pipeline.
- V has fixed priority by default; an optional starvation guard bounds P's wait.

## Interface

Parameters:
- ADDR_W, 16, RAM word address width
- DATA_W, 64, RAM word width (8 pixels of 8 bits)
- RD_LAT, 1, RAM read latency in cycles from mem_rd cycle to valid mem_q (1..4)
- STARVE_MAX, 8, consecutive P-blocked cycles before P is forced to win (guard build only, 1..255)

Ports:
- clk_FPGA  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vga_req  in  1  V read request
- vga_addr  in  ADDR_W  V word address, stable while vga_req=1
- vga_gnt  out  1  V request accepted this cycle (combinational)
- vga_rvalid  out  1  V read data valid
- vga_rdata  out  DATA_W  V read data
- proc_req  in  1  P read request
- proc_addr  in  ADDR_W  P word address, stable while proc_req=1
- proc_gnt  out  1  P request accepted this cycle (combinational)
- proc_rvalid  out  1  P read data valid
- proc_rdata  out  DATA_W  P read data
- mem_addr  out  ADDR_W  RAM port B address (registered)
- mem_rd  out  1  RAM read strobe (registered)
- mem_q  in  DATA_W  RAM port B read data
- inflight  out  3  reads issued whose data has not yet been delivered

## Operation

- Handshake:
  - A transfer occurs at a rising edge where req=1 and gnt=1.
  - gnt depends only on both req inputs and registered state; it never depends on addr.
  - A requester holds req and addr until that edge and may re-request in the following cycle (one transfer per cycle sustained).
- Arbitration, per cycle:
  - Neither req: no grant.
  - One req: that requester is granted.
  - Both req: V is granted, unless the starvation force flag is set (guard build), in which case P is granted.
  - vga_gnt and proc_gnt are never both 1.
- Issue: on a transfer edge, mem_addr <= granted addr and mem_rd <= 1. Otherwise mem_rd <= 0 and mem_addr holds its value.
- Tag pipeline: shift register of RD_LAT+1 stages, each stage {valid, id}, with id 0 = V and 1 = P.
  - Stage 0 is loaded on each edge with {transfer, winner}; all stages shift every cycle.
  - When the last stage is valid, mem_q is registered into the matching X_rdata and X_rvalid is pulsed for one cycle.
  - The other requester's rvalid stays 0.
- rdata holds its last value when rvalid=0.
- Responses return in issue order with no reordering.
- inflight = number of valid tag stages plus an rvalid currently asserted. Max RD_LAT+2; saturation cannot occur.

## Timing

- Accept edge E0 -> mem_rd=1 in cycle E0+1 -> mem_q sampled at edge E0+1+RD_LAT -> X_rvalid=1 in cycle E0+2+RD_LAT.
  - RD_LAT=1: rvalid is high during the 3rd cycle after acceptance.
- Back-to-back transfers produce back-to-back rvalid pulses with identical spacing.
- Reset values: vga_rvalid=0, proc_rvalid=0, vga_rdata=0, proc_rdata=0, mem_addr=0, mem_rd=0, inflight=0, all tag stages invalid, starvation counter=0, force flag=0.
- vga_gnt and proc_gnt are 0 whenever rst_n=0.
- Reset mid-operation clears all tags: reads issued before reset never produce rvalid after release.
- First transfer is possible at the first edge with rst_n=1.

## Configuration

- Macro VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - An 8-bit counter increments on each edge where proc_req=1 and proc_gnt=0.
  - It clears on a P transfer or when proc_req=0.
  - When the counter reaches STARVE_MAX, the force flag is set and P wins the next contested cycle.
  - The flag clears on that P transfer.
  - Worst-case P wait is STARVE_MAX+1 cycles.
- Undefined: strict V priority, and no counter or flag is present. P can starve indefinitely while vga_req stays high.

## Test plan

- Single V read, addr 0x0010, mem_q model returns 0xA5A5_0000_0000_0010 -> vga_gnt pulse at E0, mem_rd/mem_addr=0x0010 at E0+1, vga_rvalid with that data at E0+3 (RD_LAT=1), proc_rvalid stays 0.
- V and P both request every cycle for 20 cycles, guard off -> 20 V grants, 0 P grants; proc_gnt never 1.
- Same stimulus, guard on, STARVE_MAX=8 -> P granted on cycles 9 and 18, vga_gnt=0 on those cycles; no cycle with both gnt high.
- Alternating V/P back-to-back transfers with addrs 1..6 -> rvalid pulses in issue order on the correct port, each rdata equals the model word for its address, and inflight peaks at 3.
- rst_n asserted for 1 cycle while 2 reads are in flight -> all outputs go to reset values immediately; no rvalid in the 5 cycles after release; a new request after release completes normally.
